// File: rtl/keccak_digest_serializer_pkg.sv
// Shared constants and FSM encoding for the keccak digest serializer.
package keccak_digest_serializer_pkg;

    localparam int KECCAK_DIGEST_W = 512;
    localparam int KECCAK_WORD_W   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/keccak_digest_serializer_if.sv
// Valid/ready word stream carrying digest words to a narrow consumer.
interface keccak_digest_serializer_if
    import keccak_digest_serializer_pkg::*;
#(
    parameter int WORD_W = KECCAK_WORD_W
);
    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_last, input  m_ready);
    modport slave  (input  m_valid, input  m_data, input  m_last, output m_ready);
endinterface

// File: rtl/keccak_digest_serializer.sv
// Captures the keccak digest on the rising edge of out_ready and streams it
// as WORD_W-bit words, most-significant word first, marking the final word.
module keccak_digest_serializer
    import keccak_digest_serializer_pkg::*;
#(
    parameter int DIGEST_W = KECCAK_DIGEST_W,
    parameter int WORD_W   = KECCAK_WORD_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DIGEST_W-1:0]        digest_i,
    input  logic                       digest_rdy_i,
    keccak_digest_serializer_if.master m_if,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int NWORDS = DIGEST_W / WORD_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    state_e                state_q, state_d;
    logic [DIGEST_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic                  rdy_q;
    logic                  start;

    // A level already high when reset releases looks like an edge because rdy_q starts at 0.
    assign start = digest_rdy_i & ~rdy_q;

    // State, shift register, counter and edge-detect registers; reset has priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            // NOTE: the wide shift register is reset because its top word drives m_data directly and must read 0 out of reset.
            shreg_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            rdy_q   <= digest_rdy_i;
        end
    end

    // Next-state logic: capture on start, shift one word per accepted beat, stop after the last.
    always_comb begin
        // NOTE: every target gets a hold default first so no path leaves a latch behind.
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = digest_i;
                    cnt_d   = '0;
                    last_d  = (NWORDS == 1);
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (m_if.m_ready) begin
                    shreg_d = shreg_q << WORD_W;
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        last_d = (cnt_q == CNT_W'(NWORDS - 2));
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come straight from registers; m_ready only steers the enables above.
    assign m_if.m_valid = (state_q == STREAM);
    assign m_if.m_data  = shreg_q[DIGEST_W-1 -: WORD_W];
    assign m_if.m_last  = last_q;
    assign busy_o       = (state_q == STREAM);
    assign done_o       = (state_q == DONE);

endmodule
